// File: rtl/matb_col_reader.sv
// Streams matrix B out of BRAM column by column, N passes, over valid/ready.
// Issue is throttled so every in-flight read always has a FIFO slot waiting for it.
module matb_col_reader #(
    parameter int N    = 2,
    parameter int P    = 4,
    parameter int M    = 3,
    parameter int AW   = 8,
    parameter int DW   = 32,
    parameter int BASE = 0,
    parameter int FD   = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_done,
    input  logic          start,
    output logic [AW-1:0] addrb,
    input  logic [DW-1:0] doutb,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [7:0]    m_k,
    output logic [7:0]    m_col,
    output logic [7:0]    m_pass,
    output logic          m_last_k,
    output logic          m_last,
    output logic          busy,
    output logic          done
);
    localparam int PW = $clog2(N + 1);
    localparam int MW = $clog2(M + 1);
    localparam int KW = $clog2(P + 1);
    localparam int FW = (FD > 1) ? $clog2(FD) : 1;
    localparam int OW = $clog2(FD + 1);
    localparam logic [AW-1:0] BASEA = AW'(BASE);
    localparam logic [AW-1:0] STEP  = AW'(M);

    generate
        if ((longint'(BASE) + longint'(P) * longint'(M) - 1) >= (longint'(1) << AW)) begin : gBadAddr
            $error("matb_col_reader: B does not fit in the BRAM address space");
        end
        if (N < 1 || P < 1 || M < 1) begin : gBadDims
            $error("matb_col_reader: N, P and M must all be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic [PW-1:0] p;
        logic [MW-1:0] c;
        logic [KW-1:0] k;
        logic          lastK;
        logic          last;
    } tag_t;

    typedef struct packed {
        logic [DW-1:0] data;
        tag_t          tag;
    } beat_t;

    state_t        state;
    logic [PW-1:0] pCnt;
    logic [MW-1:0] cCnt;
    logic [KW-1:0] kCnt;
    logic [AW-1:0] nxtAddr;
    logic          startPend;
    logic [1:0]    vldPipe;
    tag_t          tagPipe [2];
    beat_t         fifo [FD];
    logic [FW-1:0] wrPtr, rdPtr;
    logic [OW-1:0] occ;

    logic  isLast, room, go, issue, pop;
    tag_t  curTag;
    beat_t head;

    function automatic logic [FW-1:0] ptrInc(input logic [FW-1:0] x);
        return (x == FW'(FD - 1)) ? '0 : x + FW'(1);
    endfunction

    assign isLast = (pCnt == PW'(N - 1)) && (cCnt == MW'(M - 1)) && (kCnt == KW'(P - 1));
    assign curTag = '{p: pCnt, c: cCnt, k: kCnt, lastK: (kCnt == KW'(P - 1)), last: isLast};
    // Occupancy plus outstanding reads bounds the FIFO, so data arriving from BRAM is never dropped.
    assign room   = (int'(occ) + int'(vldPipe[0]) + int'(vldPipe[1])) < FD;
    assign go     = (start | startPend) & wr_done;
    assign issue  = (state == IDLE) ? go : ((state == RUN) && room);
    assign pop    = m_valid & m_ready;

    assign head     = fifo[rdPtr];
    assign m_valid  = (occ != '0);
    assign m_data   = head.data;
    assign m_k      = 8'(head.tag.k);
    assign m_col    = 8'(head.tag.c);
    assign m_pass   = 8'(head.tag.p);
    assign m_last_k = head.tag.lastK;
    assign m_last   = head.tag.last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pCnt       <= '0;
            cCnt       <= '0;
            kCnt       <= '0;
            nxtAddr    <= BASEA;
            addrb      <= BASEA;
            startPend  <= 1'b0;
            vldPipe    <= '0;
            tagPipe[0] <= '0;
            tagPipe[1] <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done       <= 1'b0;
            vldPipe    <= {vldPipe[0], issue};
            tagPipe[1] <= tagPipe[0];
            if (issue) begin
                tagPipe[0] <= curTag;
                addrb      <= nxtAddr;
                if (kCnt == KW'(P - 1)) begin
                    kCnt <= '0;
                    if (cCnt == MW'(M - 1)) begin
                        cCnt    <= '0;
                        pCnt    <= isLast ? '0 : pCnt + PW'(1);
                        nxtAddr <= BASEA;
                    end else begin
                        cCnt    <= cCnt + MW'(1);
                        nxtAddr <= BASEA + AW'(cCnt) + AW'(1);
                    end
                end else begin
                    kCnt    <= kCnt + KW'(1);
                    nxtAddr <= nxtAddr + STEP;
                end
            end
            case (state)
                IDLE: begin
                    if (go) begin
                        state     <= isLast ? DRAIN : RUN;
                        busy      <= 1'b1;
                        startPend <= 1'b0;
                    end else if (start) begin
                        startPend <= 1'b1;
                    end
                end
                RUN: begin
                    if (issue && isLast) state <= DRAIN;
                end
                DRAIN: begin
                    if (vldPipe == 2'b00 && (occ == '0 || (occ == OW'(1) && pop))) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FD; i++) fifo[i] <= '0;
            wrPtr <= '0;
            rdPtr <= '0;
            occ   <= '0;
        end else begin
            if (vldPipe[1]) begin
                fifo[wrPtr] <= '{data: doutb, tag: tagPipe[1]};
                wrPtr       <= ptrInc(wrPtr);
            end
            if (pop) rdPtr <= ptrInc(rdPtr);
            occ <= occ + OW'(vldPipe[1]) - OW'(pop);
        end
    end
endmodule

// File: tb/tb_matb_col_reader.sv
// Directed bench for matb_col_reader: default 2x4x3 instance plus a 1x1x1 instance.
module tb_matb_col_reader;
    logic        clk = 1'b0;
    logic        reset, wr_done, start, m_ready;
    logic [7:0]  addrb;
    logic [31:0] doutb, m_data;
    logic        m_valid, m_last_k, m_last, busy, done;
    logic [7:0]  m_k, m_col, m_pass;

    logic        start1, m_ready1;
    logic [7:0]  addrb1;
    logic [31:0] doutb1, m_data1;
    logic        m_valid1, m_last_k1, m_last1, busy1, done1;
    logic [7:0]  m_k1, m_col1, m_pass1;

    always #5 clk = ~clk;

    matb_col_reader dut (
        .clk(clk), .reset(reset), .wr_done(wr_done), .start(start), .addrb(addrb), .doutb(doutb),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_k(m_k), .m_col(m_col),
        .m_pass(m_pass), .m_last_k(m_last_k), .m_last(m_last), .busy(busy), .done(done)
    );

    matb_col_reader #(.N(1), .P(1), .M(1)) u1 (
        .clk(clk), .reset(reset), .wr_done(1'b1), .start(start1), .addrb(addrb1), .doutb(doutb1),
        .m_valid(m_valid1), .m_ready(m_ready1), .m_data(m_data1), .m_k(m_k1), .m_col(m_col1),
        .m_pass(m_pass1), .m_last_k(m_last_k1), .m_last(m_last1), .busy(busy1), .done(done1)
    );

    logic [31:0] mem [256];
    initial for (int a = 0; a < 256; a++) mem[a] = 10 * (a + 1);
    always @(posedge clk) begin
        doutb  <= mem[addrb];
        doutb1 <= mem[addrb1];
    end

    typedef struct {
        logic [31:0] d;
        logic [7:0]  k, c, p;
        logic        lk, l;
    } beat_t;

    beat_t beats [$];
    beat_t cur, hold;
    logic  stalled = 1'b0;
    int    cyc = 0, doneCnt = 0, doneCyc = -1, lastCyc = -1, stallErr = 0, occErr = 0;
    int    nChk = 0, nPass = 0;
    int    expD [12] = '{10, 40, 70, 100, 20, 50, 80, 110, 30, 60, 90, 120};

    always_comb cur = '{m_data, m_k, m_col, m_pass, m_last_k, m_last};
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            stalled <= 1'b0;
        end else begin
            if (stalled && (!m_valid || m_data !== hold.d || m_k !== hold.k || m_col !== hold.c ||
                            m_pass !== hold.p || m_last_k !== hold.lk || m_last !== hold.l))
                stallErr <= stallErr + 1;
            if (m_valid && m_ready) begin
                beats.push_back(cur);
                if (m_last) lastCyc <= cyc;
            end
            stalled <= m_valid && !m_ready;
            hold    <= cur;
            if (done) begin
                doneCnt <= doneCnt + 1;
                doneCyc <= cyc;
            end
            if (int'(dut.occ) + int'(dut.vldPipe[0]) + int'(dut.vldPipe[1]) > 4) occErr <= occErr + 1;
        end
    end

    // Counts beats that differ from the expected 24-beat run (order p, c, k).
    function automatic int seqErrs();
        int e;
        e = (beats.size() == 24) ? 0 : 1;
        for (int i = 0; i < beats.size() && i < 24; i++) begin
            int r;
            r = i % 12;
            if (beats[i].d !== 32'(expD[r]) || beats[i].k !== 8'(r % 4) || beats[i].c !== 8'(r / 4) ||
                beats[i].p !== 8'(i / 12) || beats[i].lk !== (r % 4 == 3) || beats[i].l !== (i == 23))
                e++;
        end
        return e;
    endfunction

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0; m_ready = 1'b0; start1 = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        beats.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int snap;
        snap = doneCnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (doneCnt != snap) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; wr_done = 1'b0;
        @(posedge clk); #1;
        nChk++; if (m_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", m_valid); else nPass++;
        nChk++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else nPass++;
        nChk++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else nPass++;
        nChk++; if (addrb !== 8'd0) $display("FAIL reset_addrb got %0d want 0", addrb); else nPass++;
        reset = 1'b1;
    endtask

    task automatic test_basic();
        bit ok;
        apply_reset();
        wr_done = 1'b1; m_ready = 1'b1;
        pulse_start();
        nChk++; if (busy !== 1'b1) $display("FAIL basic_busy got %b want 1", busy); else nPass++;
        @(negedge clk);
        nChk++; if (m_valid !== 1'b0) $display("FAIL basic_valid_t1 got %b want 0", m_valid); else nPass++;
        @(negedge clk);
        nChk++; if (m_valid !== 1'b0) $display("FAIL basic_valid_t2 got %b want 0", m_valid); else nPass++;
        @(negedge clk);
        nChk++; if (m_valid !== 1'b1) $display("FAIL basic_valid_t3 got %b want 1", m_valid); else nPass++;
        wait_done(200, ok);
        nChk++; if (ok !== 1'b1) $display("FAIL basic_timeout got %b want 1", ok); else nPass++;
        nChk++; if (seqErrs() !== 0) $display("FAIL basic_seq got %0d errs (%0d beats) want 0", seqErrs(), beats.size()); else nPass++;
        nChk++; if (doneCyc !== lastCyc + 1) $display("FAIL basic_done_timing got %0d want %0d", doneCyc, lastCyc + 1); else nPass++;
        nChk++; if (busy !== 1'b0) $display("FAIL basic_busy_end got %b want 0", busy); else nPass++;
    endtask

    task automatic test_pending();
        bit ok;
        apply_reset();
        wr_done = 1'b0; m_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            nChk++;
            if (addrb !== 8'd0 || busy !== 1'b0 || m_valid !== 1'b0)
                $display("FAIL pend_idle%0d got addrb=%0d busy=%b valid=%b want 0/0/0", i, addrb, busy, m_valid);
            else nPass++;
            @(posedge clk); #1;
        end
        wr_done = 1'b1;
        @(posedge clk); #1;
        nChk++; if (busy !== 1'b1) $display("FAIL pend_busy got %b want 1", busy); else nPass++;
        wait_done(200, ok);
        nChk++; if (ok !== 1'b1) $display("FAIL pend_timeout got %b want 1", ok); else nPass++;
        nChk++; if (seqErrs() !== 0) $display("FAIL pend_seq got %0d errs want 0", seqErrs()); else nPass++;
    endtask

    task automatic test_backpressure();
        bit ok;
        int phase, n, snap;
        apply_reset();
        wr_done = 1'b1; m_ready = 1'b1;
        pulse_start();
        phase = 0; n = 0; ok = 1'b0; snap = doneCnt;
        for (int i = 0; i < 600; i++) begin
            if (phase == 0 && beats.size() >= 5) phase = 1;
            if (phase == 1) begin
                if (n < 10) begin
                    m_ready = 1'b0;
                    n++;
                end else phase = 2;
            end
            if (phase == 2) m_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (doneCnt != snap) begin
                ok = 1'b1;
                break;
            end
        end
        m_ready = 1'b1;
        nChk++; if (ok !== 1'b1) $display("FAIL bp_timeout got %b want 1", ok); else nPass++;
        nChk++; if (seqErrs() !== 0) $display("FAIL bp_seq got %0d errs (%0d beats) want 0", seqErrs(), beats.size()); else nPass++;
        nChk++; if (stallErr !== 0) $display("FAIL bp_stable got %0d violations want 0", stallErr); else nPass++;
        nChk++; if (occErr !== 0) $display("FAIL bp_occupancy got %0d overflows want 0", occErr); else nPass++;
    endtask

    task automatic test_start_during_run();
        bit ok;
        int snap;
        apply_reset();
        wr_done = 1'b1; m_ready = 1'b1;
        snap = doneCnt;
        pulse_start();
        repeat (6) @(posedge clk);
        #1 pulse_start();
        wait_done(200, ok);
        nChk++; if (ok !== 1'b1) $display("FAIL rerun_timeout got %b want 1", ok); else nPass++;
        nChk++; if (seqErrs() !== 0) $display("FAIL rerun_seq got %0d errs (%0d beats) want 0", seqErrs(), beats.size()); else nPass++;
        repeat (5) @(posedge clk);
        #1;
        nChk++;
        if (busy !== 1'b0 || m_valid !== 1'b0 || doneCnt !== snap + 1)
            $display("FAIL rerun_ignored got busy=%b valid=%b dones=%0d want 0/0/%0d", busy, m_valid, doneCnt - snap, 1);
        else nPass++;
        beats.delete();
        pulse_start();
        wait_done(200, ok);
        nChk++; if (ok !== 1'b1) $display("FAIL rerun2_timeout got %b want 1", ok); else nPass++;
        nChk++; if (seqErrs() !== 0) $display("FAIL rerun2_seq got %0d errs want 0", seqErrs()); else nPass++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        apply_reset();
        wr_done = 1'b1; m_ready = 1'b1;
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (beats.size() >= 7) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        nChk++; if (ok !== 1'b1) $display("FAIL rmid_reach7 got %b want 1", ok); else nPass++;
        reset = 1'b0;
        #1;
        nChk++; if (m_valid !== 1'b0) $display("FAIL rmid_valid got %b want 0", m_valid); else nPass++;
        nChk++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b want 0", busy); else nPass++;
        nChk++; if (done !== 1'b0) $display("FAIL rmid_done got %b want 0", done); else nPass++;
        nChk++; if (addrb !== 8'd0) $display("FAIL rmid_addrb got %0d want 0", addrb); else nPass++;
        @(posedge clk); #1;
        reset = 1'b1;
        beats.delete();
        pulse_start();
        wait_done(200, ok);
        nChk++; if (ok !== 1'b1) $display("FAIL rmid_timeout got %b want 1", ok); else nPass++;
        nChk++; if (seqErrs() !== 0) $display("FAIL rmid_seq got %0d errs want 0", seqErrs()); else nPass++;
    endtask

    task automatic test_tiny();
        int bc, bCyc, dCyc;
        logic [31:0] d;
        logic lk, l;
        apply_reset();
        m_ready1 = 1'b1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        bc = 0; bCyc = -1; dCyc = -1; d = '0; lk = 1'b0; l = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_valid1 && m_ready1) begin
                bc++; d = m_data1; lk = m_last_k1; l = m_last1; bCyc = i;
            end
            if (done1) dCyc = i;
        end
        nChk++; if (bc !== 1) $display("FAIL tiny_count got %0d want 1", bc); else nPass++;
        nChk++; if (d !== 32'd10) $display("FAIL tiny_data got %0d want 10", d); else nPass++;
        nChk++; if (lk !== 1'b1 || l !== 1'b1) $display("FAIL tiny_last got lk=%b l=%b want 1/1", lk, l); else nPass++;
        nChk++; if (dCyc !== bCyc + 1 || bCyc < 0) $display("FAIL tiny_done got %0d want %0d", dCyc, bCyc + 1); else nPass++;
        nChk++; if (busy1 !== 1'b0) $display("FAIL tiny_busy got %b want 0", busy1); else nPass++;
    endtask

    initial begin
        reset = 1'b0; wr_done = 1'b0; start = 1'b0; m_ready = 1'b0;
        start1 = 1'b0; m_ready1 = 1'b1;
        test_reset();
        test_basic();
        test_pending();
        test_backpressure();
        test_start_during_run();
        test_reset_mid();
        test_tiny();
        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end
endmodule
